// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage sitting directly behind the PC.
// Samples the PC, issues one instruction-memory read per accepted address,
// and buffers {pc, instruction} pairs in a small FIFO for decode.
//
// Ports:
//   clk          sole clock, all state updates on posedge
//   reset        asynchronous active-low reset
//   pc           current PC value
//   flush        redirect this cycle; discards buffered and in-flight work
//   pc_stall     1 = pc not consumed this cycle, PC must hold
//   imem_req     registered memory read request
//   imem_addr    registered memory read address
//   imem_ack     memory returns data this cycle
//   imem_rdata   read data, valid with imem_ack
//   instr_valid  FIFO head valid
//   instr        head instruction
//   instr_pc     address of head instruction
//   instr_ready  decode consumes head when instr_valid & instr_ready
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    output logic              pc_stall,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              instr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t            state, state_next;
    logic              req_next;
    logic [ADDR_W-1:0] addr_next;

    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic room, accept, push, pop;

    // While a request is outstanding its result already owns one slot.
    // A pop in the same cycle is deliberately not credited.
    always_comb begin
        if (state == IDLE)
            room = (count < CW'(DEPTH));
        else
            room = ((count + CW'(1)) < CW'(DEPTH));
    end

    assign accept   = !flush && room && ((state == IDLE) || ((state == REQ) && imem_ack));
    assign pc_stall = reset ? !accept : 1'b0;
    assign push     = (state == REQ) && imem_ack && !flush;
    assign pop      = instr_valid && instr_ready && !flush;

    assign instr_valid = (count != '0);
    assign instr       = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= '0;
        end else begin
            state     <= state_next;
            imem_req  <= req_next;
            imem_addr <= addr_next;
        end
    end

    // A request is never retracted: flush without ack parks in DRAIN with
    // req/addr held until the memory answers, then drops the data.
    always_comb begin
        state_next = state;
        req_next   = imem_req;
        addr_next  = imem_addr;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = REQ;
                    req_next   = 1'b1;
                    addr_next  = pc;
                end
            end
            REQ: begin
                if (flush) begin
                    if (imem_ack) begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (imem_ack) begin
                    if (accept) begin
                        addr_next = pc;
                    end else begin
                        state_next = IDLE;
                        req_next   = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (imem_ack) begin
                    state_next = IDLE;
                    req_next   = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem[i]   <= '0;
                data_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]   <= imem_addr;
                data_mem[wr_ptr] <= imem_rdata;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue.
// Inputs are driven right after each falling edge; outputs are checked 1ns
// later, well away from the rising edge.
module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [ADDR_W-1:0] pc = '0;
    logic              flush = 1'b0;
    logic              pc_stall;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset(reset), .pc(pc), .flush(flush), .pc_stall(pc_stall),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // Push into a full FIFO, or occupancy beyond DEPTH, is a design error.
    always @(negedge clk) begin
        #4;
        if (reset === 1'b1) begin
            n_checks++;
            if ((dut.push && int'(dut.count) == DEPTH) || int'(dut.count) > DEPTH) begin
                n_fail++;
                $display("FAIL overflow: count=%0d push=%0b, required push into full FIFO never", dut.count, dut.push);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b0; flush = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
        pc = '0; imem_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        do_reset;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== '0) begin
            n_fail++; $display("FAIL reset_req: req=%0b addr=%h, required 0/0", imem_req, imem_addr);
        end
        n_checks++;
        if (instr_valid !== 1'b0 || instr !== '0 || instr_pc !== '0) begin
            n_fail++; $display("FAIL reset_fifo: valid=%0b instr=%h pc=%h, required 0", instr_valid, instr, instr_pc);
        end
        n_checks++;
        if (pc_stall !== 1'b0) begin
            n_fail++; $display("FAIL reset_stall: got %0b, required 0", pc_stall);
        end
    endtask

    task automatic test_zero_wait;
        do_reset;
        for (int k = 0; k < 8; k++) begin
            reset = 1'b1; pc = 32'(4 * k); imem_ack = 1'b1; instr_ready = 1'b1; flush = 1'b0;
            imem_rdata = mem_word(imem_addr);
            #1;
            n_checks++;
            if (pc_stall !== 1'b0) begin
                n_fail++; $display("FAIL zw_stall k=%0d: got %0b, required 0", k, pc_stall);
            end
            n_checks++;
            if (imem_req !== (k >= 1) || (k >= 1 && imem_addr !== 32'(4 * (k - 1)))) begin
                n_fail++; $display("FAIL zw_addr k=%0d: req=%0b addr=%h, required req=%0b addr=%h", k, imem_req, imem_addr, k >= 1, 4 * (k - 1));
            end
            n_checks++;
            if (instr_valid !== (k >= 2) ||
                (k >= 2 && (instr_pc !== 32'(4 * (k - 2)) || instr !== mem_word(32'(4 * (k - 2)))))) begin
                n_fail++; $display("FAIL zw_instr k=%0d: valid=%0b pc=%h instr=%h, required valid=%0b pc=%h", k, instr_valid, instr_pc, instr, k >= 2, 4 * (k - 2));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_wait3;
        int ph;
        do_reset;
        for (int k = 0; k < 13; k++) begin
            ph = (k >= 1) ? (k - 1) % 3 : 0;
            reset = 1'b1; instr_ready = 1'b1; flush = 1'b0;
            pc = (k == 0) ? 32'h100 : 32'(32'h100 + 4 * (1 + (k - 1) / 3));
            imem_ack = (k >= 1) && (ph == 2);
            imem_rdata = mem_word(imem_addr);
            #1;
            n_checks++;
            if (pc_stall !== ((k >= 1) && (ph != 2))) begin
                n_fail++; $display("FAIL w3_stall k=%0d: got %0b, required %0b", k, pc_stall, (k >= 1) && (ph != 2));
            end
            if (k >= 1) begin
                n_checks++;
                if (imem_req !== 1'b1 || imem_addr !== 32'(32'h100 + 4 * ((k - 1) / 3))) begin
                    n_fail++; $display("FAIL w3_addr k=%0d: req=%0b addr=%h, required 1/%h", k, imem_req, imem_addr, 32'h100 + 4 * ((k - 1) / 3));
                end
            end
            n_checks++;
            if (instr_valid !== (k >= 4 && ph == 0) ||
                (k >= 4 && ph == 0 && instr_pc !== 32'(32'h100 + 4 * ((k - 4) / 3)))) begin
                n_fail++; $display("FAIL w3_instr k=%0d: valid=%0b pc=%h, required valid=%0b pc=%h", k, instr_valid, instr_pc, k >= 4 && ph == 0, 32'h100 + 4 * ((k - 4) / 3));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_fill;
        int t_pc    [13] = '{0, 4, 8, 12, 16, 16, 16, 16, 16, 16, 20, 24, 28};
        int t_rdy   [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
        int t_stall [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        int t_addr  [13] = '{-1, 0, 4, 8, 12, -1, -1, -1, -1, -1, 16, 20, 24};
        int t_ipc   [13] = '{-1, -1, 0, 0, 0, 0, 0, 0, 0, 4, 8, 12, 16};
        do_reset;
        for (int k = 0; k < 13; k++) begin
            reset = 1'b1; flush = 1'b0; imem_ack = 1'b1;
            pc = 32'(t_pc[k]); instr_ready = (t_rdy[k] != 0);
            imem_rdata = mem_word(imem_addr);
            #1;
            n_checks++;
            if (pc_stall !== (t_stall[k] != 0)) begin
                n_fail++; $display("FAIL fill_stall k=%0d: got %0b, required %0d", k, pc_stall, t_stall[k]);
            end
            n_checks++;
            if (imem_req !== (t_addr[k] >= 0) || (t_addr[k] >= 0 && imem_addr !== 32'(t_addr[k]))) begin
                n_fail++; $display("FAIL fill_req k=%0d: req=%0b addr=%h, required addr=%0d (-1 = idle)", k, imem_req, imem_addr, t_addr[k]);
            end
            n_checks++;
            if (instr_valid !== (t_ipc[k] >= 0) || (t_ipc[k] >= 0 && instr_pc !== 32'(t_ipc[k]))) begin
                n_fail++; $display("FAIL fill_head k=%0d: valid=%0b pc=%h, required pc=%0d (-1 = empty)", k, instr_valid, instr_pc, t_ipc[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_drain;
        int t_pc    [8] = '{'h10, 'h14, 'h40, 'h40, 'h40, 'h40, 'h44, 'h48};
        int t_fl    [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
        int t_ack   [8] = '{0, 1, 0, 0, 1, 0, 1, 0};
        int t_rdy   [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        int t_stall [8] = '{0, 0, 1, 1, 1, 0, 0, 1};
        int t_addr  [8] = '{-1, 'h10, 'h14, 'h14, 'h14, -1, 'h40, 'h44};
        int t_ipc   [8] = '{-1, -1, 'h10, -1, -1, -1, -1, 'h40};
        do_reset;
        for (int k = 0; k < 8; k++) begin
            reset = 1'b1; pc = 32'(t_pc[k]); flush = (t_fl[k] != 0);
            imem_ack = (t_ack[k] != 0); instr_ready = (t_rdy[k] != 0);
            imem_rdata = (k == 4) ? 32'hDEAD_BEEF : mem_word(imem_addr);
            #1;
            n_checks++;
            if (pc_stall !== (t_stall[k] != 0)) begin
                n_fail++; $display("FAIL fd_stall k=%0d: got %0b, required %0d", k, pc_stall, t_stall[k]);
            end
            n_checks++;
            if (imem_req !== (t_addr[k] >= 0) || (t_addr[k] >= 0 && imem_addr !== 32'(t_addr[k]))) begin
                n_fail++; $display("FAIL fd_req k=%0d: req=%0b addr=%h, required addr=%0h (-1 = idle)", k, imem_req, imem_addr, t_addr[k]);
            end
            n_checks++;
            if (instr_valid !== (t_ipc[k] >= 0) ||
                (t_ipc[k] >= 0 && (instr_pc !== 32'(t_ipc[k]) || instr !== mem_word(32'(t_ipc[k])))) ||
                (instr_valid === 1'b1 && instr === 32'hDEAD_BEEF)) begin
                n_fail++; $display("FAIL fd_head k=%0d: valid=%0b pc=%h instr=%h, required pc=%0h (-1 = empty)", k, instr_valid, instr_pc, instr, t_ipc[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_ack;
        int t_pc    [8] = '{0, 4, 8, 12, 'h80, 'h80, 'h84, 'h88};
        int t_fl    [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        int t_rdy   [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int t_stall [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
        int t_addr  [8] = '{-1, 0, 4, 8, 12, -1, 'h80, 'h84};
        int t_ipc   [8] = '{-1, -1, 0, 0, 0, -1, -1, 'h80};
        do_reset;
        for (int k = 0; k < 8; k++) begin
            reset = 1'b1; pc = 32'(t_pc[k]); flush = (t_fl[k] != 0);
            imem_ack = 1'b1; instr_ready = (t_rdy[k] != 0);
            imem_rdata = mem_word(imem_addr);
            #1;
            n_checks++;
            if (pc_stall !== (t_stall[k] != 0)) begin
                n_fail++; $display("FAIL fa_stall k=%0d: got %0b, required %0d", k, pc_stall, t_stall[k]);
            end
            n_checks++;
            if (imem_req !== (t_addr[k] >= 0) || (t_addr[k] >= 0 && imem_addr !== 32'(t_addr[k]))) begin
                n_fail++; $display("FAIL fa_req k=%0d: req=%0b addr=%h, required addr=%0h (-1 = idle)", k, imem_req, imem_addr, t_addr[k]);
            end
            n_checks++;
            if (instr_valid !== (t_ipc[k] >= 0) ||
                (t_ipc[k] >= 0 && (instr_pc !== 32'(t_ipc[k]) || instr !== mem_word(32'(t_ipc[k]))))) begin
                n_fail++; $display("FAIL fa_head k=%0d: valid=%0b pc=%h instr=%h, required pc=%0h (-1 = empty)", k, instr_valid, instr_pc, instr, t_ipc[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset;
        do_reset;
        reset = 1'b1; pc = 32'h200; imem_ack = 1'b0; instr_ready = 1'b0;
        @(negedge clk);
        pc = 32'h204; imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++; $display("FAIL ar_req: req=%0b addr=%h, required 1/00000200", imem_req, imem_addr);
        end
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || imem_addr !== 32'h204) begin
            n_fail++; $display("FAIL ar_pre: valid=%0b pc=%h addr=%h, required 1/200/204", instr_valid, instr_pc, imem_addr);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || imem_addr !== '0 || instr_valid !== 1'b0 || instr_pc !== '0 || instr !== '0) begin
            n_fail++; $display("FAIL ar_drop: req=%0b addr=%h valid=%0b pc=%h instr=%h, required all 0", imem_req, imem_addr, instr_valid, instr_pc, instr);
        end
        n_checks++;
        if (pc_stall !== 1'b0) begin
            n_fail++; $display("FAIL ar_stall: got %0b, required 0", pc_stall);
        end
        @(negedge clk);
        reset = 1'b1; pc = 32'h300; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b1;
        #1;
        n_checks++;
        if (pc_stall !== 1'b0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL ar_stray: stall=%0b req=%0b valid=%0b, required 0/0/0", pc_stall, imem_req, instr_valid);
        end
        @(negedge clk);
        pc = 32'h304; imem_ack = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0) begin
            n_fail++; $display("FAIL ar_refetch: req=%0b addr=%h valid=%0b, required 1/300/0", imem_req, imem_addr, instr_valid);
        end
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = mem_word(imem_addr);
        #1;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h300 || instr !== mem_word(32'h300)) begin
            n_fail++; $display("FAIL ar_result: valid=%0b pc=%h instr=%h, required 1/300/%h", instr_valid, instr_pc, instr, mem_word(32'h300));
        end
    endtask

    initial begin
        test_reset;
        test_zero_wait;
        test_wait3;
        test_fill;
        test_flush_drain;
        test_flush_ack;
        test_async_reset;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Each cycle it samples the PC's current address, issues one instruction-memory read, and buffers {pc, instruction} pairs in a small FIFO for decode.
- Back-pressures the PC through pc_stall, and discards all fetched and in-flight work on a branch/redirect flush.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- ADDR_W, 32, PC/address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pc  in  ADDR_W  current PC value (program counter currData).
- flush  in  1  redirect: PC is being loaded by a branch or register write this cycle.
- pc_stall  out  1  1 = pc not consumed this cycle; PC must hold its value.
- imem_req  out  1  memory read request (registered).
- imem_addr  out  ADDR_W  read address (registered).
- imem_ack  in  1  memory returns data this cycle.
- imem_rdata  in  DATA_W  read data, valid when imem_ack=1.
- instr_valid  out  1  FIFO head valid.
- instr  out  DATA_W  head instruction.
- instr_pc  out  ADDR_W  address of head instruction.
- instr_ready  in  1  decode consumes head when instr_valid & instr_ready.

Behaviour:
- Reset (reset=0, asynchronous, any state): state=IDLE; count=0; rd/wr pointers=0; all FIFO storage=0.
  - Outputs during and after reset: imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, pc_stall=0.
  - Reset mid-request drops the transaction; a late imem_ack is ignored while in IDLE.
- States: IDLE (no request outstanding), REQ (request outstanding, result wanted), DRAIN (request outstanding, result to be discarded).
- room:
  - In IDLE: room = (count < DEPTH).
  - In REQ/DRAIN: room = (count+1 < DEPTH); the pending entry is reserved.
  - Same-cycle pop is not credited.
- accept = !flush & room & (state==IDLE | (state==REQ & imem_ack)).
- pc_stall = !accept (combinational).
- On accept: imem_addr<=pc, imem_req<=1, next state REQ.
- Bus rule: once imem_req=1, imem_req and imem_addr must stay stable until the cycle imem_ack=1. A request is never retracted, including on flush.
- imem_ack is only meaningful while imem_req=1. An ack in IDLE is ignored.
- REQ & imem_ack & !flush: push {imem_addr, imem_rdata}.
  - If accept, stay REQ with the new address, giving back-to-back fetches at 1 per cycle.
  - Else imem_req<=0, go IDLE.
- REQ & !imem_ack: hold.
- Flush (highest priority):
  - count<=0, pointers<=0; instr_valid=0 from the next cycle.
  - No push, no accept; a pop that cycle is ignored.
  - state REQ & imem_ack: discard data, imem_req<=0, go IDLE.
  - state REQ & !imem_ack: go DRAIN.
  - state DRAIN: stay DRAIN until ack.
  - state IDLE: stay IDLE.
- DRAIN: hold req/addr. On imem_ack, discard data, imem_req<=0, go IDLE. pc_stall=1 throughout.
- FIFO:
  - instr_valid = (count != 0); instr and instr_pc come from the head entry.
  - pop = instr_valid & instr_ready & !flush.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible by the credit rule. A push into a full FIFO is a design error and must be asserted against in the bench.
- Latency with a zero-wait memory (ack in the first req cycle):
  - pc accepted in cycle N;
  - imem_req=1 in N+1;
  - instr_valid=1 with instr_pc=pc in N+2.
- Widths: no arithmetic on addresses; pc is passed through unchanged.

Test Plan:
- Reset then zero-wait memory, ack held 1, instr_ready=1, pc=0,4,8,12… → imem_addr follows pc one cycle later; instr_pc 0,4,8… one per cycle from cycle 2; pc_stall=0 throughout.
- Memory with 3-cycle ack latency, ack high on every third req cycle → imem_addr/imem_req stable across wait cycles; pc_stall=1 on non-ack cycles; exactly one instr per request, in order.
- DEPTH=4, instr_ready=0, zero-wait memory → 4 entries fill; pc_stall=1 once count+reservation reaches 4; count never exceeds 4. Raise ready → entries drain in order 0,4,8,12; fetch resumes.
- Flush in a REQ cycle without ack, ack 2 cycles later with rdata=0xDEADBEEF → state DRAIN, instr_valid=0 next cycle, 0xDEADBEEF never appears; first post-drain fetch uses the redirected pc (e.g. 0x40).
- Flush coincident with imem_ack and instr_ready=1 on a 3-entry FIFO → acked data dropped, FIFO empty next cycle, IDLE, pc_stall=1 only in the flush cycle.
- Assert reset=0 asynchronously mid-REQ (between clock edges) → imem_req, instr_valid, imem_addr drop to 0 immediately; a stray ack after release is ignored.
